// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: three-stage pipelined floating-point multiplier.
// Generic format {sign, EXP_W exponent, MAN_W fraction}. Subnormals flush to zero.
// Rounding is either nearest-even or truncation. Special values follow IEEE style.
// Every stage carries its own valid bit, and back-pressure propagates from out_ready.
module fp_mult_pipe #(
  parameter int EXP_W = 6,
  parameter int MAN_W = 11,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  input  logic         rnd_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] R,
  output logic [3:0]   flags
);

  localparam int MW   = MAN_W + 1;
  localparam int PW   = 2 * MW;
  localparam int EW   = EXP_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic [W-1:0]    CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [EW-2:0]   EXP_MAX   = {1'b0, {EXP_W{1'b1}}};

  // Stage-enable chain
  logic w_load1, w_load2, w_load3;

  // Stage-1 combinational signals
  logic             w_s;
  logic [EXP_W-1:0] w_ex, w_ey;
  logic [MAN_W-1:0] w_fx, w_fy;
  logic             w_x_zero, w_y_zero, w_x_inf, w_y_inf, w_x_nan, w_y_nan;
  logic             w_spec;
  logic [W-1:0]     w_spec_r;
  logic [3:0]       w_spec_f;
  logic [PW-1:0]    w_prod;
  logic [EW-1:0]    w_exp;

  // Stage-1 registers
  logic             r1_valid, r1_sign, r1_rnd, r1_spec;
  logic [W-1:0]     r1_spec_r;
  logic [3:0]       r1_spec_f;
  logic [PW-1:0]    r1_prod;
  logic [EW-1:0]    r1_exp;

  // Stage-2 combinational signals
  logic             w_hi, w_guard, w_sticky, w_rup, w_ovf, w_unf;
  logic [MAN_W-1:0] w_frac_pre;
  logic [MAN_W:0]   w_frac_r;
  logic [EW-1:0]    w_exp_f;
  logic [W-1:0]     w_res;
  logic [3:0]       w_flags;

  // Stage-2 and stage-3 registers
  logic             r2_valid, r3_valid;
  logic [W-1:0]     r2_r, r3_r;
  logic [3:0]       r2_f, r3_f;

  // A stage loads when it is empty or its contents move on in the same cycle
  always_comb begin
    w_load3 = !r3_valid || out_ready;
    w_load2 = !r2_valid || w_load3;
    w_load1 = !r1_valid || w_load2;
  end

  assign in_ready  = w_load1;
  assign out_valid = r3_valid;
  assign R         = r3_r;
  assign flags     = r3_f;

  assign w_s  = X[W-1] ^ Y[W-1];
  assign w_ex = X[W-2:MAN_W];
  assign w_ey = Y[W-2:MAN_W];
  assign w_fx = X[MAN_W-1:0];
  assign w_fy = Y[MAN_W-1:0];
  assign w_x_zero = (w_ex == '0);
  assign w_y_zero = (w_ey == '0);
  assign w_x_inf  = (w_ex == '1) && (w_fx == '0);
  assign w_y_inf  = (w_ey == '1) && (w_fy == '0);
  assign w_x_nan  = (w_ex == '1) && (w_fx != '0);
  assign w_y_nan  = (w_ey == '1) && (w_fy != '0);
  assign w_prod   = PW'({1'b1, w_fx}) * PW'({1'b1, w_fy});
  assign w_exp    = EW'(w_ex) + EW'(w_ey) - EW'(BIAS);

  // Classify operands; special results override the normal path in priority order
  always_comb begin
    w_spec   = 1'b1;
    w_spec_r = '0;
    w_spec_f = '0;
    if (w_x_nan || w_y_nan || (w_x_inf && w_y_zero) || (w_x_zero && w_y_inf)) begin
      w_spec_r = CANON_NAN;
      w_spec_f = 4'b1000;
    end else if (w_x_inf || w_y_inf) begin
      w_spec_r = {w_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_x_zero || w_y_zero) begin
      w_spec_r = {w_s, {(W-1){1'b0}}};
    end else begin
      w_spec = 1'b0;
    end
  end

  // Stage 1: capture classification, exponent sum and raw mantissa product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid  <= 1'b0;
      r1_sign   <= 1'b0;
      r1_rnd    <= 1'b0;
      r1_spec   <= 1'b0;
      r1_spec_r <= '0;
      r1_spec_f <= '0;
      r1_prod   <= '0;
      r1_exp    <= '0;
    end else if (w_load1) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_sign   <= w_s;
        r1_rnd    <= rnd_mode;
        r1_spec   <= w_spec;
        r1_spec_r <= w_spec_r;
        r1_spec_f <= w_spec_f;
        r1_prod   <= w_prod;
        r1_exp    <= w_exp;
      end
    end
  end

  // Normalisation selects the fraction window directly instead of shifting the whole product
  assign w_hi       = r1_prod[PW-1];
  assign w_frac_pre = w_hi ? r1_prod[PW-2 -: MAN_W] : r1_prod[PW-3 -: MAN_W];
  assign w_guard    = w_hi ? r1_prod[PW-MW-1] : r1_prod[PW-MW-2];
  assign w_sticky   = w_hi ? (|r1_prod[PW-MW-2:0]) : (|r1_prod[PW-MW-3:0]);
  assign w_rup      = !r1_rnd && w_guard && (w_sticky || w_frac_pre[0]);
  // A carry out of the fraction means the mantissa became 2.0: the low bits are already zero
  assign w_frac_r   = {1'b0, w_frac_pre} + (MAN_W+1)'(w_rup);
  assign w_exp_f    = r1_exp + EW'(w_hi) + EW'(w_frac_r[MAN_W]);
  assign w_unf      = w_exp_f[EW-1] || (w_exp_f == '0);
  assign w_ovf      = !w_exp_f[EW-1] && (w_exp_f[EW-2:0] >= EXP_MAX);

  // Stage-2 result: special value, overflow, underflow or rounded normal
  always_comb begin
    w_res   = {r1_sign, w_exp_f[EXP_W-1:0], w_frac_r[MAN_W-1:0]};
    w_flags = {3'b000, w_guard || w_sticky};
    if (r1_spec) begin
      w_res   = r1_spec_r;
      w_flags = r1_spec_f;
    end else if (w_ovf) begin
      w_flags = 4'b0101;
      if (r1_rnd) w_res = {r1_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      else        w_res = {r1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_unf) begin
      w_res   = {r1_sign, {(W-1){1'b0}}};
      w_flags = 4'b0011;
    end
  end

  // Stage 2: hold the finished result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid <= 1'b0;
      r2_r     <= '0;
      r2_f     <= '0;
    end else if (w_load2) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_r <= w_res;
        r2_f <= w_flags;
      end
    end
  end

  // Stage 3: output register, frozen while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_valid <= 1'b0;
      r3_r     <= '0;
      r3_f     <= '0;
    end else if (w_load3) begin
      r3_valid <= r2_valid;
      if (r2_valid) begin
        r3_r <= r2_r;
        r3_f <= r2_f;
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: directed vector table, reset/back-pressure sequences and a
// randomly stalled stream compared in order against a behavioural model.
module tb_fp_mult_pipe;

  typedef struct {
    logic [17:0] x;
    logic [17:0] y;
    logic        rm;
    logic [17:0] r;
    logic [3:0]  f;
  } vec_t;

  typedef struct {
    logic [17:0] r;
    logic [3:0]  f;
  } res_t;

  logic        clk, rst_n, in_valid, in_ready, rnd_mode, out_valid, out_ready;
  logic [17:0] X, Y, R;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;
  res_t exp_q[$];
  logic acc, del;
  logic stall_prev;
  logic [17:0] stall_r;
  logic [3:0]  stall_f;
  string cur_name;

  fp_mult_pipe #(.EXP_W(6), .MAN_W(11)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .Y(Y), .rnd_mode(rnd_mode), .out_valid(out_valid),
    .out_ready(out_ready), .R(R), .flags(flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s [%s]: got %0h expected %0h", name, cur_name, act, expv);
    end
  endtask

  function automatic res_t model(input logic [17:0] x, input logic [17:0] y, input logic rm);
    res_t o;
    logic s, xn, yn, xi, yi, xz, yz, inex;
    logic [5:0] ex, ey;
    logic [10:0] fx, fy;
    longint p, kept, rem, half;
    int e, sh;
    s  = x[17] ^ y[17];
    ex = x[16:11]; ey = y[16:11];
    fx = x[10:0];  fy = y[10:0];
    xn = (ex == 6'h3F) && (fx != 0); yn = (ey == 6'h3F) && (fy != 0);
    xi = (ex == 6'h3F) && (fx == 0); yi = (ey == 6'h3F) && (fy == 0);
    xz = (ex == 0); yz = (ey == 0);
    o.f = 4'b0000;
    if (xn || yn || (xi && yz) || (xz && yi)) begin
      o.r = 18'h1FC00; o.f = 4'b1000;
      return o;
    end
    if (xi || yi) begin
      o.r = {s, 6'h3F, 11'h000};
      return o;
    end
    if (xz || yz) begin
      o.r = {s, 17'h0};
      return o;
    end
    p = longint'({1'b1, fx}) * longint'({1'b1, fy});
    e = int'(ex) + int'(ey) - 31;
    if (p >= (longint'(1) << 23)) begin sh = 12; e = e + 1; end
    else sh = 11;
    kept = p >> sh;
    rem  = p - (kept << sh);
    half = longint'(1) << (sh - 1);
    inex = (rem != 0);
    if (!rm && ((rem > half) || ((rem == half) && (kept % 2 == 1)))) kept = kept + 1;
    if (kept == 4096) begin kept = 2048; e = e + 1; end
    if (e >= 63) begin
      o.r = rm ? {s, 6'h3E, 11'h7FF} : {s, 6'h3F, 11'h000};
      o.f = 4'b0101;
    end else if (e <= 0) begin
      o.r = {s, 17'h0};
      o.f = 4'b0011;
    end else begin
      o.r = {s, 6'(e), 11'(kept - 2048)};
      o.f = {3'b000, inex};
    end
    return o;
  endfunction

  function automatic logic [17:0] rand_op();
    int k;
    logic [17:0] v;
    k = $urandom_range(0, 15);
    v = 18'($urandom);
    if (k == 0) v[16:11] = 6'h00;
    else if (k == 1) begin v[16:11] = 6'h3F; v[10:0] = 11'h000; end
    else if (k == 2) begin v[16:11] = 6'h3F; v[10] = 1'b1; end
    else v[16:11] = 6'($urandom_range(10, 52));
    return v;
  endfunction

  // One clock cycle: drive at the falling edge, sample 1 time unit later,
  // and book-keep what the following rising edge will transfer.
  task automatic cycle(input logic iv, input logic [17:0] x, input logic [17:0] y,
                       input logic rm, input logic ordy, input res_t e);
    res_t got;
    @(negedge clk);
    in_valid = iv; X = x; Y = y; rnd_mode = rm; out_ready = ordy;
    #1;
    check("in_ready", 32'(in_ready), 32'(!((exp_q.size() == 3) && !ordy)));
    if (stall_prev) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_R", 32'(R), 32'(stall_r));
      check("hold_flags", 32'(flags), 32'(stall_f));
    end
    acc = iv && in_ready;
    del = out_valid && ordy;
    if (del) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output [%s]: got R=%0h with nothing in flight", cur_name, R);
      end else begin
        got = exp_q.pop_front();
        check("R", 32'(R), 32'(got.r));
        check("flags", 32'(flags), 32'(got.f));
      end
    end
    if (acc) exp_q.push_back(e);
    stall_prev = out_valid && !ordy;
    stall_r = R;
    stall_f = flags;
  endtask

  task automatic run_vec(input logic [17:0] x, input logic [17:0] y, input logic rm, input res_t e);
    int n;
    logic got;
    res_t none;
    none.r = '0; none.f = '0;
    cycle(1'b1, x, y, rm, 1'b1, e);
    check("accept", 32'(acc), 32'd1);
    n = 0; got = 1'b0;
    while (!got && n < 10) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1, none);
      n++;
      got = del;
    end
    check("latency", 32'(n), 32'd3);
  endtask

  vec_t vecs[14];

  initial begin
    res_t e, none;
    int tries, n;
    logic [17:0] x, y;
    logic rm;

    vecs[0]  = '{x:18'h0F800, y:18'h0F800, rm:1'b0, r:18'h0F800, f:4'b0000};
    vecs[1]  = '{x:18'h0FC00, y:18'h0FC00, rm:1'b0, r:18'h10100, f:4'b0000};
    vecs[2]  = '{x:18'h2FC00, y:18'h0F800, rm:1'b0, r:18'h2FC00, f:4'b0000};
    vecs[3]  = '{x:18'h1F7FF, y:18'h10000, rm:1'b0, r:18'h1F800, f:4'b0101};
    vecs[4]  = '{x:18'h1F7FF, y:18'h10000, rm:1'b1, r:18'h1F7FF, f:4'b0101};
    vecs[5]  = '{x:18'h00000, y:18'h1F800, rm:1'b0, r:18'h1FC00, f:4'b1000};
    vecs[6]  = '{x:18'h00800, y:18'h00800, rm:1'b0, r:18'h00000, f:4'b0011};
    vecs[7]  = '{x:18'h1F801, y:18'h0F800, rm:1'b0, r:18'h1FC00, f:4'b1000};
    vecs[8]  = '{x:18'h1F800, y:18'h30000, rm:1'b0, r:18'h3F800, f:4'b0000};
    vecs[9]  = '{x:18'h20000, y:18'h0F800, rm:1'b0, r:18'h20000, f:4'b0000};
    vecs[10] = '{x:18'h00001, y:18'h0F800, rm:1'b0, r:18'h00000, f:4'b0000};
    vecs[11] = '{x:18'h0FC00, y:18'h0F801, rm:1'b0, r:18'h0FC02, f:4'b0001};
    vecs[12] = '{x:18'h0FC00, y:18'h0F801, rm:1'b1, r:18'h0FC01, f:4'b0001};
    vecs[13] = '{x:18'h0F801, y:18'h0F801, rm:1'b0, r:18'h0F802, f:4'b0001};

    none.r = '0; none.f = '0;
    stall_prev = 1'b0; stall_r = '0; stall_f = '0;
    acc = 1'b0; del = 1'b0;
    in_valid = 1'b0; X = '0; Y = '0; rnd_mode = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    cur_name = "reset";
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_R", 32'(R), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      cur_name = $sformatf("vec%0d", i);
      e.r = vecs[i].r; e.f = vecs[i].f;
      run_vec(vecs[i].x, vecs[i].y, vecs[i].rm, e);
    end

    // Fill all three stages under back-pressure, then reset mid-flight
    cur_name = "reset_midflight";
    e.r = 18'h0F800; e.f = 4'b0000;
    for (int i = 0; i < 4; i++) cycle(1'b1, 18'h0F800, 18'h0F800, 1'b0, 1'b0, e);
    check("full_accepts", 32'(exp_q.size()), 32'd3);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_R", 32'(R), 32'd0);
    check("midrst_flags", 32'(flags), 32'd0);
    exp_q.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cur_name = "after_reset";
    e.r = 18'h10100; e.f = 4'b0000;
    run_vec(18'h0FC00, 18'h0FC00, 1'b0, e);

    // Stream 100 pairs; first 30 with out_ready held high, rest randomly stalled
    cur_name = "stream";
    for (int i = 0; i < 100; i++) begin
      x = rand_op(); y = rand_op(); rm = 1'($urandom_range(0, 1));
      e = model(x, y, rm);
      tries = 0;
      do begin
        cycle(1'b1, x, y, rm, (i < 30) ? 1'b1 : 1'($urandom_range(0, 2) != 0), e);
        tries++;
      end while (!acc && tries < 50);
      if (!acc) begin
        checks++; errors++;
        $display("FAIL stream_accept_timeout: pair %0d not accepted, expected within 50 cycles", i);
      end
    end
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      cycle(1'b0, '0, '0, 1'b0, 1'($urandom_range(0, 1)), none);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, none);
    check("idle_out_valid", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
